trng_aes_arb: RTL and testbench

TRNG_AES_ARB -- requirements
Module: trng_aes_arb

---
 rtl/trng_aes_arb.sv | 178 +++++++++++++++++
 tb/tb_trng_aes_arb.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/trng_aes_arb.sv
// Round-robin arbiter sharing one AES core between the CTR-DRBG engine (r0) and the
// conditioner (r1); abandoned operations are drained so stale results never leak.
module trng_aes_arb #(
    parameter logic [15:0] TIMEOUT = 16'd1024
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         r0_req,
    input  logic [127:0] r0_key,
    input  logic [127:0] r0_text,
    input  logic         r0_sel,
    input  logic         r1_req,
    input  logic [127:0] r1_key,
    input  logic [127:0] r1_text,
    input  logic         r1_sel,
    output logic         r0_gnt,
    output logic         r1_gnt,
    output logic         r0_done,
    output logic         r1_done,
    output logic         r0_err,
    output logic         r1_err,
    output logic [255:0] rdata,
    output logic         aes_start,
    output logic [127:0] aes_key,
    output logic [127:0] aes_text_in,
    output logic         aes_sel,
    input  logic         aes_done,
    input  logic [255:0] aes_text_out,
    output logic         busy,
    output logic         gnt_id
);

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, RESP, DRAIN} state_t;

    localparam logic [15:0] TMAX = TIMEOUT - 16'd1;

    state_t        state_q, state_d;
    logic          last_gnt_q, last_gnt_d;
    logic [15:0]   timer_q, timer_d;
    logic [1:0]    gnt_q, gnt_d;
    logic [1:0]    done_q, done_d;
    logic [1:0]    err_q, err_d;
    logic          aes_start_q, aes_start_d;
    logic [127:0]  aes_key_q, aes_key_d;
    logic [127:0]  aes_text_q, aes_text_d;
    logic          aes_sel_q, aes_sel_d;
    logic [255:0]  rdata_q, rdata_d;
    logic          gnt_id_q, gnt_id_d;
    logic          busy_q, busy_d;

    logic          win;
    logic          timed_out;
    logic [15:0]   timer_hold;
    logic [1:0]    owner_onehot;

    always_comb begin
        state_d      = state_q;
        last_gnt_d   = last_gnt_q;
        timer_d      = timer_q;
        gnt_d        = 2'b00;
        done_d       = 2'b00;
        err_d        = 2'b00;
        aes_start_d  = 1'b0;
        aes_key_d    = aes_key_q;
        aes_text_d   = aes_text_q;
        aes_sel_d    = aes_sel_q;
        rdata_d      = rdata_q;
        gnt_id_d     = gnt_id_q;

        // On a tie the requester that did not finish last wins.
        win          = (r0_req && r1_req) ? ~last_gnt_q : r1_req;
        timed_out    = (timer_q == TMAX);
        // Under a held flush the timer parks at the limit instead of wrapping.
        timer_hold   = timed_out ? timer_q : timer_q + 16'd1;
        owner_onehot = gnt_id_q ? 2'b10 : 2'b01;

        case (state_q)
            IDLE: begin
                if (!flush && (r0_req || r1_req)) begin
                    state_d     = ISSUE;
                    gnt_id_d    = win;
                    gnt_d       = win ? 2'b10 : 2'b01;
                    aes_start_d = 1'b1;
                    aes_key_d   = win ? r1_key  : r0_key;
                    aes_text_d  = win ? r1_text : r0_text;
                    aes_sel_d   = win ? r1_sel  : r0_sel;
                end
            end
            ISSUE: begin
                timer_d = 16'd0;
                state_d = flush ? DRAIN : WAIT;
            end
            WAIT: begin
                if (flush) begin
                    state_d = DRAIN;
                    timer_d = timer_hold;
                end else if (aes_done) begin
                    state_d    = RESP;
                    rdata_d    = aes_text_out;
                    last_gnt_d = gnt_id_q;
                    done_d     = owner_onehot;
                end else if (timed_out) begin
                    state_d    = RESP;
                    last_gnt_d = gnt_id_q;
                    done_d     = owner_onehot;
                    err_d      = owner_onehot;
                end else begin
                    timer_d = timer_q + 16'd1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            DRAIN: begin
                if (flush) begin
                    timer_d = timer_hold;
                end else if (aes_done || timed_out) begin
                    state_d = IDLE;
                end else begin
                    timer_d = timer_q + 16'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            last_gnt_q  <= 1'b1;
            timer_q     <= 16'd0;
            gnt_q       <= 2'b00;
            done_q      <= 2'b00;
            err_q       <= 2'b00;
            aes_start_q <= 1'b0;
            aes_key_q   <= '0;
            aes_text_q  <= '0;
            aes_sel_q   <= 1'b0;
            rdata_q     <= '0;
            gnt_id_q    <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_gnt_q  <= last_gnt_d;
            timer_q     <= timer_d;
            gnt_q       <= gnt_d;
            done_q      <= done_d;
            err_q       <= err_d;
            aes_start_q <= aes_start_d;
            aes_key_q   <= aes_key_d;
            aes_text_q  <= aes_text_d;
            aes_sel_q   <= aes_sel_d;
            rdata_q     <= rdata_d;
            gnt_id_q    <= gnt_id_d;
            busy_q      <= busy_d;
        end
    end

    assign r0_gnt      = gnt_q[0];
    assign r1_gnt      = gnt_q[1];
    assign r0_done     = done_q[0];
    assign r1_done     = done_q[1];
    assign r0_err      = err_q[0];
    assign r1_err      = err_q[1];
    assign rdata       = rdata_q;
    assign aes_start   = aes_start_q;
    assign aes_key     = aes_key_q;
    assign aes_text_in = aes_text_q;
    assign aes_sel     = aes_sel_q;
    assign gnt_id      = gnt_id_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_trng_aes_arb.sv
// Directed bench for trng_aes_arb: single op, round-robin, timeout, flush/drain,
// done-vs-timeout race and mid-operation reset.
module tb_trng_aes_arb;

    logic         clk = 1'b0;
    logic         rst, flush;
    logic         r0_req, r1_req, r0_sel, r1_sel;
    logic [127:0] r0_key, r0_text, r1_key, r1_text;
    logic         r0_gnt, r1_gnt, r0_done, r1_done, r0_err, r1_err;
    logic [255:0] rdata;
    logic         aes_start, aes_sel, aes_done, busy, gnt_id;
    logic [127:0] aes_key, aes_text_in;
    logic [255:0] aes_text_out;

    int           checks = 0;
    int           errors = 0;
    logic [255:0] exp_rdata;
    logic [255:0] v;

    always #5 clk = ~clk;

    trng_aes_arb #(.TIMEOUT(16'd8)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .r0_req(r0_req), .r0_key(r0_key), .r0_text(r0_text), .r0_sel(r0_sel),
        .r1_req(r1_req), .r1_key(r1_key), .r1_text(r1_text), .r1_sel(r1_sel),
        .r0_gnt(r0_gnt), .r1_gnt(r1_gnt), .r0_done(r0_done), .r1_done(r1_done),
        .r0_err(r0_err), .r1_err(r1_err), .rdata(rdata),
        .aes_start(aes_start), .aes_key(aes_key), .aes_text_in(aes_text_in),
        .aes_sel(aes_sel), .aes_done(aes_done), .aes_text_out(aes_text_out),
        .busy(busy), .gnt_id(gnt_id)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; aes_done = 1'b0; aes_text_out = '0;
        r0_req = 1'b0; r1_req = 1'b0; r0_sel = 1'b0; r1_sel = 1'b0;
        r0_key = {16{8'h11}}; r0_text = {16{8'h22}};
        r1_key = {16{8'h33}}; r1_text = {16{8'h44}};
        exp_rdata = '0;
        tick(); tick();
        chk("rst_busy", busy, 0);
        chk("rst_gnt_id", gnt_id, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_key", aes_key, 0);
        chk("rst_start", aes_start, 0);
        chk("rst_gnts", {r1_gnt, r0_gnt, r1_done, r0_done}, 0);
        rst = 1'b0;

        // Single r0 operation, aes_done at t+5
        r0_req = 1'b1; r0_sel = 1'b1;
        tick();
        chk("t1_r0_gnt", r0_gnt, 1);
        chk("t1_r1_gnt", r1_gnt, 0);
        chk("t1_start", aes_start, 1);
        chk("t1_key", aes_key, {16{8'h11}});
        chk("t1_text", aes_text_in, {16{8'h22}});
        chk("t1_sel", aes_sel, 1);
        chk("t1_busy", busy, 1);
        chk("t1_gnt_id", gnt_id, 0);
        r0_req = 1'b0; r0_sel = 1'b0;
        tick();
        chk("t1_start_off", aes_start, 0);
        chk("t1_gnt_off", r0_gnt, 0);
        tick(); tick(); tick();
        aes_done = 1'b1; aes_text_out = {8{32'hDEAD_BEEF}};
        chk("t1_no_early_done", r0_done, 0);
        tick();
        exp_rdata = {8{32'hDEAD_BEEF}};
        aes_done = 1'b0; aes_text_out = '0;
        chk("t1_done", r0_done, 1);
        chk("t1_err", r0_err, 0);
        chk("t1_r1_done", r1_done, 0);
        chk("t1_rdata", rdata, exp_rdata);
        tick();
        chk("t1_done_off", r0_done, 0);
        chk("t1_idle", busy, 0);
        chk("t1_rdata_hold", rdata, exp_rdata);

        // Round-robin from reset: r0, r1, r0, r1
        rst = 1'b1; tick(); rst = 1'b0;
        exp_rdata = '0;
        r0_req = 1'b1; r1_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("rr_gnt", {r1_gnt, r0_gnt}, (i % 2) ? 2'b10 : 2'b01);
            chk("rr_gnt_id", gnt_id, i % 2);
            chk("rr_key", aes_key, (i % 2) ? {16{8'h33}} : {16{8'h11}});
            tick();
            v = {8{32'hC0DE_F00D}} ^ {224'd0, 32'(i)};
            aes_done = 1'b1; aes_text_out = v;
            tick();
            exp_rdata = v;
            aes_done = 1'b0;
            chk("rr_done", {r1_done, r0_done}, (i % 2) ? 2'b10 : 2'b01);
            chk("rr_rdata", rdata, exp_rdata);
            tick();
        end
        r0_req = 1'b0; r1_req = 1'b0;
        tick();

        // Timeout on r1 with TIMEOUT=8
        r1_req = 1'b1;
        tick();
        chk("to_gnt", r1_gnt, 1);
        r1_req = 1'b0;
        tick();
        for (int i = 0; i < 7; i++) tick();
        chk("to_not_yet", r1_done, 0);
        tick();
        chk("to_done", r1_done, 1);
        chk("to_err", r1_err, 1);
        chk("to_r0_done", r0_done, 0);
        chk("to_rdata", rdata, exp_rdata);
        tick();
        chk("to_done_off", {r1_done, r1_err}, 0);
        chk("to_idle", busy, 0);

        // Flush in WAIT, r1 requests while draining
        r0_req = 1'b1;
        tick();
        chk("fl_start", aes_start, 1);
        r0_req = 1'b0;
        tick();
        flush = 1'b1; r1_req = 1'b1;
        tick();
        flush = 1'b0;
        chk("fl_drain_busy", busy, 1);
        chk("fl_no_gnt", r1_gnt, 0);
        tick();
        aes_done = 1'b1; aes_text_out = {8{32'h5A1E_5A1E}};
        chk("fl_no_gnt2", r1_gnt, 0);
        tick();
        aes_done = 1'b0; aes_text_out = '0;
        chk("fl_no_done", {r1_done, r0_done}, 0);
        chk("fl_no_gnt3", r1_gnt, 0);
        chk("fl_rdata", rdata, exp_rdata);
        chk("fl_idle", busy, 0);
        tick();
        chk("fl_r1_gnt", r1_gnt, 1);
        chk("fl_gnt_id", gnt_id, 1);
        r1_req = 1'b0;
        tick();
        aes_done = 1'b1; aes_text_out = {8{32'hF2E5_0001}};
        tick();
        exp_rdata = {8{32'hF2E5_0001}};
        aes_done = 1'b0; aes_text_out = '0;
        chk("fl_r1_done", r1_done, 1);
        chk("fl_r1_err", r1_err, 0);
        chk("fl_r0_done", r0_done, 0);
        chk("fl_r1_rdata", rdata, exp_rdata);
        tick();

        // aes_done in the same cycle the timer hits TIMEOUT-1
        r0_req = 1'b1;
        tick();
        r0_req = 1'b0;
        tick();
        for (int i = 0; i < 7; i++) tick();
        chk("race_no_early", r0_done, 0);
        aes_done = 1'b1; aes_text_out = {8{32'h0BAD_CAFE}};
        tick();
        exp_rdata = {8{32'h0BAD_CAFE}};
        aes_done = 1'b0; aes_text_out = '0;
        chk("race_done", r0_done, 1);
        chk("race_err", r0_err, 0);
        chk("race_rdata", rdata, exp_rdata);
        tick();

        // Flush in IDLE suppresses the grant
        flush = 1'b1; r0_req = 1'b1;
        tick();
        chk("fi_no_gnt", r0_gnt, 0);
        chk("fi_idle", busy, 0);
        flush = 1'b0; r0_req = 1'b0;
        tick();

        // Reset while in WAIT, then a late aes_done
        r1_req = 1'b1;
        tick();
        r1_req = 1'b0;
        tick(); tick();
        chk("rw_busy_pre", busy, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rw_busy", busy, 0);
        chk("rw_gnt_id", gnt_id, 0);
        chk("rw_key", aes_key, 0);
        chk("rw_text", aes_text_in, 0);
        chk("rw_rdata", rdata, 0);
        aes_done = 1'b1; aes_text_out = {8{32'hBADD_0D0E}};
        tick();
        aes_done = 1'b0; aes_text_out = '0;
        chk("rw_no_done", {r1_done, r0_done, r1_err, r0_err}, 0);
        chk("rw_busy2", busy, 0);
        chk("rw_rdata2", rdata, 0);
        tick();
        chk("rw_quiet", {r1_done, r0_done, r1_gnt, r0_gnt, aes_start}, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
